mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM pipeline stage, successor to the pass-through MEM stage; sits between EX/MEM and MEM/WB registers.
- Forwards writeback and HI/LO information as before, and adds parametrised load/store execution against a req/ack data-memory port.
- Handles byte/half/word alignment (big-endian), sign/zero extension, misalignment detection, a bounded ack timeout and a pipeline stall request.

Parameters:
- DATA_W, 32: register/data width; must be 32 in this generation (byte lanes assume 4 lanes).
- ADDR_W, 32: data-memory address width.
- REG_ADDR_W, 5: register-file address width.
- TIMEOUT, 15: max WAIT cycles without mem_ack_i before the bus error; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as NONE
- mem_addr_i  in  ADDR_W  effective address from EX
- store_data_i  in  DATA_W  rt value for stores
- wreg_i / waddr_i / wdata_i  in  1 / REG_ADDR_W / DATA_W  writeback request from EX
- whilo_i / hi_i / lo_i  in  1 / DATA_W / DATA_W  HI/LO write from EX
- wreg_o / waddr_o / wdata_o  out  1 / REG_ADDR_W / DATA_W  to MEM/WB
- whilo_o / hi_o / lo_o  out  1 / DATA_W / DATA_W  to MEM/WB
- stallreq_o  out  1  stall request to pipeline control
- addr_err_o  out  1  misaligned access, one-cycle pulse
- bus_err_o  out  1  ack timeout, one-cycle pulse
- dmem_req_o / dmem_we_o  out  1 / 1  memory request / write enable
- dmem_sel_o  out  4  byte-lane enables; bit3 = bits 31:24
- dmem_addr_o  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
- dmem_wdata_o  out  DATA_W  store data replicated into the lanes
- dmem_ack_i  in  1  one-cycle completion
- dmem_rdata_i  in  DATA_W  valid when ack=1

Behaviour:
- Reset: while rst=1, every output is 0, FSM goes to IDLE, wait counter 0, captured data 0; rst overrides an in-flight access (request dropped, no result).
- NONE ops: zero latency, combinational pass-through of all wreg/whilo/hi/lo inputs; no stall.
- FSM states are IDLE, WAIT, DONE.
- IDLE with an aligned memory op:
  - dmem_req_o=1 and stallreq_o=1 in the same cycle.
  - Next state is WAIT, or DONE if dmem_ack_i=1 in that cycle.
- WAIT:
  - dmem_req_o=1 and stallreq_o=1; the address, sel and data are held (inputs are stable because the pipeline is stalled).
  - Counter increments each WAIT cycle.
  - ack -> capture dmem_rdata_i, go to DONE.
  - Counter==TIMEOUT with no ack -> go to DONE with the error flag set.
- DONE: req=0, stall=0, outputs driven from the captured result for exactly one cycle; next state IDLE. Minimum load/store latency is 1 stall cycle plus the DONE cycle.
- Lanes (big-endian):
  - Byte at offset k -> sel bit (3-k).
  - Half at offset 0 -> 4'b1100; offset 2 -> 4'b0011.
  - Word -> 4'b1111.
  - SB replicates store_data_i[7:0] into all 4 lanes; SH replicates [15:0] into both halves.
- Loads: the selected lane goes to wdata_o; LB/LH sign-extend, LBU/LHU zero-extend; wreg_o/waddr_o come from the inputs.
- Stores: wreg_o forced 0 in DONE unless the op is SC.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW/LL/SC with addr[1:0]!=0):
  - No request is issued and there is no stall.
  - addr_err_o=1 for that cycle and wreg_o=0; whilo/hi/lo still pass through.
- Timeout: bus_err_o=1 in DONE and wreg_o=0.
- A late ack arriving in IDLE is ignored.

Optional Feature:
- Macro LLSC_EN.
- Defined: a 1-bit link register is added. Clear conditions take precedence over the set.
  - Set when an LL completes in DONE.
  - Cleared by rst, by any SC completing, or by a timeout.
  - SC with link=1 performs a word store; DONE writes 1 to rt (wreg_o=1).
  - SC with link=0 issues no request, no stall, zero latency; wreg_o=1, wdata_o=0.
- Undefined: LL behaves as LW; SC behaves as SW with wreg_o=0.

Test Plan:
- LB, addr 0x1003, rdata 0x11223380, ack after 2 WAIT cycles -> stallreq high 3 cycles, sel 4'b0001, DONE wdata_o=0xFFFFFF80, wreg_o=1.
- LHU, addr 0x2002, rdata 0xAAAA8001, ack in issue cycle -> 1 stall cycle, sel 4'b0011, wdata_o=0x00008001.
- SH, addr 0x30, store_data 0xDEADBEEF -> dmem_we_o=1, sel 4'b1100, wdata 0xBEEFBEEF, dmem_addr_o=0x30, wreg_o=0 in DONE.
- LW, addr 0x1002 -> no dmem_req_o, addr_err_o pulse 1 cycle, wreg_o=0, stallreq_o=0.
- LW with ack never asserted, TIMEOUT=15 -> stall for 16 cycles, bus_err_o pulse, FSM back in IDLE; rst asserted mid-WAIT -> all outputs 0 the next cycle.
- LLSC_EN: LL 0x40, then SC 0x40 -> store issued, wdata_o=1; second SC 0x40 -> no request, wdata_o=0, no stall.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data-memory port between the MEM stage and data memory.
// master drives the request side; slave returns ack and read data.
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, sel, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, sel, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage with a big-endian load/store unit on a req/ack port.
// Define LLSC_EN to add the LL/SC link register.
module mem_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic                  wreg_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  whilo_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  output logic                  wreg_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o,
  output logic                  addr_err_o,
  output logic                  bus_err_o,
  mem_lsu_if.master             dmem
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;

  logic is_ld, is_st, is_sc;
  logic sz_b, sz_h, sz_w, sgn;
  logic is_mem, misalign, go;
  logic sc_fail, sc_wr;

  logic [3:0]        sel_w;
  logic [DATA_W-1:0] st_w;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] cap_val;
  logic              req_w;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    is_sc = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    sgn   = 1'b0;
    case (mem_op_i)
      OP_LB:  begin is_ld = 1'b1; sz_b = 1'b1; sgn = 1'b1; end
      OP_LBU: begin is_ld = 1'b1; sz_b = 1'b1; end
      OP_LH:  begin is_ld = 1'b1; sz_h = 1'b1; sgn = 1'b1; end
      OP_LHU: begin is_ld = 1'b1; sz_h = 1'b1; end
      OP_LW,
      OP_LL:  begin is_ld = 1'b1; sz_w = 1'b1; end
      OP_SB:  begin is_st = 1'b1; sz_b = 1'b1; end
      OP_SH:  begin is_st = 1'b1; sz_h = 1'b1; end
      OP_SW:  begin is_st = 1'b1; sz_w = 1'b1; end
      OP_SC:  begin is_st = 1'b1; sz_w = 1'b1; is_sc = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_ld | is_st;
  assign misalign = (sz_h & mem_addr_i[0])
                  | (sz_w & (mem_addr_i[1:0] != 2'b00));
  assign go       = is_mem & ~misalign & ~sc_fail;

`ifdef LLSC_EN
  logic link_q;

  // Clearing wins over setting, so a timed-out LL never links.
  always_ff @(posedge clk) begin
    if (rst)
      link_q <= 1'b0;
    else if (state_q == S_DONE && (is_sc || err_q))
      link_q <= 1'b0;
    else if (state_q == S_DONE && mem_op_i == OP_LL)
      link_q <= 1'b1;
  end

  assign sc_fail = is_sc & ~link_q;
  assign sc_wr   = 1'b1;
`else
  assign sc_fail = 1'b0;
  assign sc_wr   = 1'b0;
`endif

  always_comb begin
    sel_w = 4'b0000;
    st_w  = '0;
    unique case (1'b1)
      sz_b: begin
        sel_w = 4'b1000 >> mem_addr_i[1:0];
        st_w  = {4{store_data_i[7:0]}};
      end
      sz_h: begin
        sel_w = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_w  = {2{store_data_i[15:0]}};
      end
      sz_w: begin
        sel_w = 4'b1111;
        st_w  = store_data_i;
      end
      default: ;
    endcase
  end

  // Offset 0 is the most significant lane.
  assign ld_b = dmem.rdata[{~mem_addr_i[1:0], 3'b000} +: 8];
  assign ld_h = mem_addr_i[1] ? dmem.rdata[15:0] : dmem.rdata[31:16];

  always_comb begin
    ld_val = dmem.rdata;
    if (sz_b)
      ld_val = {{(DATA_W-8){sgn & ld_b[7]}}, ld_b};
    else if (sz_h)
      ld_val = {{(DATA_W-16){sgn & ld_h[15]}}, ld_h};
  end

  assign cap_val = is_ld ? ld_val : DATA_W'(is_sc & sc_wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    err_d      = err_q;
    req_w      = 1'b0;
    stallreq_o = 1'b0;
    addr_err_o = 1'b0;
    bus_err_o  = 1'b0;
    wreg_o     = wreg_i;
    waddr_o    = waddr_i;
    wdata_o    = wdata_i;
    whilo_o    = whilo_i;
    hi_o       = hi_i;
    lo_o       = lo_i;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        err_d = 1'b0;
        if (go) begin
          req_w      = 1'b1;
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          whilo_o    = 1'b0;
          if (dmem.ack) begin
            res_d   = cap_val;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (is_mem && misalign) begin
          addr_err_o = 1'b1;
          wreg_o     = 1'b0;
        end else if (sc_fail) begin
          wreg_o  = 1'b1;
          wdata_o = '0;
        end
      end
      S_WAIT: begin
        req_w      = 1'b1;
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        whilo_o    = 1'b0;
        if (dmem.ack) begin
          res_d   = cap_val;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        wreg_o    = ~err_q & (is_ld ? wreg_i : (is_sc & sc_wr));
        wdata_o   = res_q;
        bus_err_o = err_q;
        cnt_d     = 8'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      req_w      = 1'b0;
      stallreq_o = 1'b0;
      addr_err_o = 1'b0;
      bus_err_o  = 1'b0;
      wreg_o     = 1'b0;
      waddr_o    = '0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
    end
  end

  assign dmem.req   = req_w;
  assign dmem.we    = req_w & is_st;
  assign dmem.sel   = req_w ? sel_w : 4'b0000;
  assign dmem.addr  = req_w ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.wdata = (req_w & is_st) ? st_w : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors for mem_lsu with a queue-based scoreboard.
// Define LLSC_EN for both DUT and bench to exercise LL/SC.
module tb_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, store_data_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o, addr_err_o, bus_err_o;

  mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

  mem_lsu #(
    .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .wreg_i       (wreg_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .whilo_i      (whilo_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .wreg_o       (wreg_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .stallreq_o   (stallreq_o),
    .addr_err_o   (addr_err_o),
    .bus_err_o    (bus_err_o),
    .dmem         (dmem.master)
  );

  typedef struct packed {
    int          id;
    int          stalls;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        aerr;
    logic        berr;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] baddr;
    logic [31:0] bwd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_id = 0;
  logic active = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(input int id, input string what,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL t%0d %s: got %h, want %h", id, what, got, want);
    end
  endtask

  function automatic logic any_out();
    return |{wreg_o, waddr_o, wdata_o, whilo_o, hi_o, lo_o,
             stallreq_o, addr_err_o, bus_err_o,
             dmem.req, dmem.we, dmem.sel, dmem.addr, dmem.wdata};
  endfunction

  initial begin : monitor
    int          ns;
    logic        seen, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wd;
    exp_t        e;
    ns = 0; seen = 1'b0; s_we = 1'b0;
    s_sel = 4'b0; s_addr = 32'b0; s_wd = 32'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        ns = 0; seen = 1'b0;
      end else if (active && stallreq_o) begin
        ns++;
        if (dmem.req && !seen) begin
          seen   = 1'b1;
          s_we   = dmem.we;
          s_sel  = dmem.sel;
          s_addr = dmem.addr;
          s_wd   = dmem.wdata;
        end
      end else if (active) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL t%0d result with empty queue", last_id);
        end else begin
          e = q.pop_front();
          chk(e.id, "stall cycles", 32'(ns), 32'(e.stalls));
          chk(e.id, "wreg_o", 32'(wreg_o), 32'(e.wreg));
          if (e.wreg) begin
            chk(e.id, "waddr_o", 32'(waddr_o), 32'(e.waddr));
            chk(e.id, "wdata_o", wdata_o, e.wdata);
          end
          chk(e.id, "whilo_o", 32'(whilo_o), 32'(e.whilo));
          chk(e.id, "hi_o", hi_o, e.hi);
          chk(e.id, "lo_o", lo_o, e.lo);
          chk(e.id, "addr_err_o", 32'(addr_err_o), 32'(e.aerr));
          chk(e.id, "bus_err_o", 32'(bus_err_o), 32'(e.berr));
          chk(e.id, "req seen", 32'(seen), 32'(e.req));
          if (e.req) begin
            chk(e.id, "dmem sel", 32'(s_sel), 32'(e.sel));
            chk(e.id, "dmem we", 32'(s_we), 32'(e.we));
            chk(e.id, "dmem addr", s_addr, e.baddr);
            chk(e.id, "dmem wdata", s_wd, e.bwd);
          end
        end
        ns = 0; seen = 1'b0;
      end else begin
        chk(last_id, "idle stall/req/err",
            32'({stallreq_o, dmem.req, addr_err_o, bus_err_o}), 32'd0);
      end
    end
  end

  task automatic idle();
    mem_op_i  = 4'd0;
    dmem.ack  = 1'b0;
    wreg_i    = 1'b0;
    whilo_i   = 1'b0;
    active    = 1'b0;
  endtask

  task automatic run(input int id, input logic [3:0] op,
                     input logic [31:0] addr, input logic [31:0] sd,
                     input logic [31:0] rd, input int ack_at,
                     input int stalls, input logic ewreg,
                     input logic [31:0] ewd, input logic aerr,
                     input logic berr, input logic req, input logic we,
                     input logic [3:0] sel, input logic [31:0] bwd);
    exp_t e;
    int   cyc;
    bit   done;
    @(posedge clk); #2;
    last_id      = id;
    mem_op_i     = op;
    mem_addr_i   = addr;
    store_data_i = sd;
    dmem.rdata   = rd;
    wreg_i       = 1'b1;
    waddr_i      = id[4:0];
    wdata_i      = 32'h1000_0000 + id;
    whilo_i      = id[0];
    hi_i         = 32'hA000_0000 + id;
    lo_i         = 32'hB000_0000 + id;
    dmem.ack     = (ack_at == 0);
    e = '{id: id, stalls: stalls, wreg: ewreg, waddr: id[4:0],
          wdata: ewd, whilo: id[0], hi: 32'hA000_0000 + id,
          lo: 32'hB000_0000 + id, aerr: aerr, berr: berr, req: req,
          we: we, sel: sel, baddr: {addr[31:2], 2'b00}, bwd: bwd};
    q.push_back(e);
    active = 1'b1;
    done   = 1'b0;
    cyc    = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (!stallreq_o) done = 1'b1;
      else begin
        @(posedge clk); #2;
        cyc++;
        dmem.ack = (ack_at == cyc);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL t%0d stall never released: got %0d cycles, want %0d",
               id, cyc, stalls);
    end
    @(posedge clk); #2;
    idle();
  endtask

  initial begin
    rst          = 1'b1;
    mem_op_i     = 4'd5;
    mem_addr_i   = 32'h0000_0010;
    store_data_i = 32'hFFFF_FFFF;
    wreg_i       = 1'b1;
    waddr_i      = 5'd7;
    wdata_i      = 32'hFFFF_FFFF;
    whilo_i      = 1'b1;
    hi_i         = 32'hFFFF_FFFF;
    lo_i         = 32'hFFFF_FFFF;
    dmem.ack     = 1'b1;
    dmem.rdata   = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(0, "reset all outputs", 32'(any_out()), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle();
    mon_en = 1'b1;

    //  id op     addr          sd            rd            ack st wr wdata         ae be rq we sel      bwd
    run(1, 4'd1, 32'h1003, 32'h0,        32'h11223380, 2, 3, 1, 32'hFFFFFF80, 0, 0, 1, 0, 4'b0001, 32'h0);
    run(2, 4'd4, 32'h2002, 32'h0,        32'hAAAA8001, 0, 1, 1, 32'h00008001, 0, 0, 1, 0, 4'b0011, 32'h0);
    run(3, 4'd7, 32'h0030, 32'hDEADBEEF, 32'h0,        1, 2, 0, 32'h0,        0, 0, 1, 1, 4'b1100, 32'hBEEFBEEF);
    run(5, 4'd5, 32'h1002, 32'h0,        32'h0,       -1, 0, 0, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
    run(6, 4'd5, 32'h0100, 32'h0,        32'h0,       -1, 16, 0, 32'h0,       0, 1, 1, 0, 4'b1111, 32'h0);
    run(7, 4'd0, 32'h0,    32'h0,        32'h0,        0, 0, 1, 32'h10000007, 0, 0, 0, 0, 4'b0000, 32'h0);
    run(8, 4'd3, 32'h0040, 32'h0,        32'h80017FFF, 1, 2, 1, 32'hFFFF8001, 0, 0, 1, 0, 4'b1100, 32'h0);
    run(9, 4'd2, 32'h0041, 32'h0,        32'h12F45678, 0, 1, 1, 32'h000000F4, 0, 0, 1, 0, 4'b0100, 32'h0);
    run(10, 4'd6, 32'h0052, 32'h000000A5, 32'h0,       0, 1, 0, 32'h0,        0, 0, 1, 1, 4'b0010, 32'hA5A5A5A5);
    run(11, 4'd3, 32'h0043, 32'h0,        32'h0,      -1, 0, 0, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
    run(12, 4'd8, 32'h0060, 32'h01234567, 32'h0,       3, 4, 0, 32'h0,        0, 0, 1, 1, 4'b1111, 32'h01234567);
    run(13, 4'd7, 32'h0033, 32'h0000BEEF, 32'h0,      -1, 0, 0, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
    run(14, 4'd3, 32'h0042, 32'h0,        32'h12347FFF, 0, 1, 1, 32'h00007FFF, 0, 0, 1, 0, 4'b0011, 32'h0);

    mon_en  = 1'b0;
    last_id = 20;
    @(posedge clk); #2;
    mem_op_i   = 4'd5;
    mem_addr_i = 32'h0000_0200;
    wreg_i     = 1'b1;
    whilo_i    = 1'b1;
    dmem.ack   = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(20, "stall mid-wait", 32'(stallreq_o), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk(20, "rst mid-wait outputs", 32'(any_out()), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk(20, "after rst stall/req/err",
        32'({stallreq_o, dmem.req, bus_err_o, addr_err_o}), 32'd0);
    mon_en = 1'b1;

    run(21, 4'd5, 32'h0070, 32'h0, 32'h89ABCDEF, 0, 1, 1, 32'h89ABCDEF, 0, 0, 1, 0, 4'b1111, 32'h0);
`ifdef LLSC_EN
    run(22, 4'd9,  32'h0040, 32'h0,    32'h00000099, 0, 1, 1, 32'h00000099, 0, 0, 1, 0, 4'b1111, 32'h0);
    run(23, 4'd10, 32'h0040, 32'h1234, 32'h0,        0, 1, 1, 32'h00000001, 0, 0, 1, 1, 4'b1111, 32'h1234);
    run(24, 4'd10, 32'h0040, 32'h5678, 32'h0,       -1, 0, 1, 32'h00000000, 0, 0, 0, 0, 4'b0000, 32'h0);
`else
    run(22, 4'd9,  32'h0084, 32'h0,    32'h00000005, 0, 1, 1, 32'h00000005, 0, 0, 1, 0, 4'b1111, 32'h0);
    run(23, 4'd10, 32'h0080, 32'h77,   32'h0,        1, 2, 0, 32'h0,        0, 0, 1, 1, 4'b1111, 32'h77);
`endif

    repeat (2) @(posedge clk);
    chk(99, "scoreboard drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
